dir_hist_scan: RTL
==================

// Module: dir_hist_scan
// PURPOSE
//  Reads the 16x16 direction-offset ROM (8-bit addr, 5-bit signed mod-32 offset) in step with a pixel stream.
//  Per pixel: rel = pix_ori - rom_spo (mod 32); 8-bin index = rel[4:2]; bin accumulates pix_mag.
//  After 256 pixels, drains the 8-bin histogram serially to the descriptor stage.
//  Sits between the gradient unit (pixel stream) and the descriptor normaliser.
// PARAMETERS
//  MAG_W   8    gradient magnitude width
//  ACC_W   16   histogram accumulator width (MAG_W+8 makes overflow impossible)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      begin a window; honoured in IDLE only
//  busy        out  1      high in ACCUM or DRAIN
//  pix_valid   in   1      pixel present
//  pix_ready   out  1      pixel accepted when valid&&ready
//  pix_ori     in   5      quantised gradient orientation, 32 steps
//  pix_mag     in   MAG_W  gradient magnitude, unsigned
//  rom_a       out  8      ROM address = {row[3:0], col[3:0]} = pixel counter
//  rom_spo     in   5      ROM data, combinational, same cycle as rom_a
//  hist_valid  out  1      histogram word present
//  hist_ready  in   1      consumer accepts
//  hist_bin    out  3      bin index of hist_data
//  hist_data   out  ACC_W  accumulated magnitude
//  hist_last   out  1      high with bin 7
//  done        out  1      one-cycle pulse after bin 7 handshake
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, bin_idx=0, all 8 accumulators=0; outputs busy, pix_ready, hist_valid, hist_last, done = 0;
//   rom_a, hist_bin, hist_data = 0.
//  FSM IDLE -> ACCUM on start (clears accumulators and cnt that edge). ACCUM -> DRAIN on handshake with cnt==255.
//   DRAIN -> IDLE on hist handshake with bin_idx==7; done=1 next cycle.
//  ACCUM: pix_ready=1 and rom_a=cnt (registered). Handshake: acc[rel[4:2]] += pix_mag; cnt++.
//   No handshake: nothing changes. Latency: accumulate visible 1 cycle after handshake.
//  rel = (pix_ori - rom_spo) & 5'h1f: pure 5-bit wrap, no sign extension.
//  Accumulate saturates at 2^ACC_W-1. It never wraps.
//  DRAIN: hist_valid=1; hist_bin=bin_idx; hist_data=acc[bin_idx]; hist_last=(bin_idx==7).
//   Data holds stable while !hist_ready. bin_idx++ on each handshake.
//  start outside IDLE: ignored. start in the same cycle as done: accepted (IDLE already entered).
//  rst_n low mid-window: immediate return to reset values. Partial histogram discarded, no done.
// CONFIGURATION
//  DIR_HIST_CENTER_WEIGHT_EN defined: outer-ring pixels (row or col in 0..3 or 12..15) add pix_mag>>1.
//   Inner 8x8 pixels add full pix_mag.
//  Undefined: every pixel adds full pix_mag. Port list identical in both builds.
// STRUCTURE
//  Package sift_dir_pkg holds:
//   - state enum {IDLE, ACCUM, DRAIN}
//   - WIN=16, NBINS=8, ROM_AW=8, ROM_DW=5, ORI_STEPS=32
//   - function bin_of(ori, spo)
//  Sub-module dir_hist_bank: 8 x ACC_W saturating accumulators.
//   Inputs: clear, add_en, add_bin, add_val.
//   Output: read port by bin_idx.
//  Top holds the FSM, counters and the ROM address drive. The ROM is instantiated outside, next to this block.
// TESTING
//  1. ROM model; pix_ori=rom_spo(cnt), mag=1 for all 256 -> bin0=256, bins1-7=0, hist_last on 8th word.
//  2. Wrap: addr 15 (spo=0x1e), ori=0x02, mag=9, all others mag=0 -> rel=0x04, bin1=9.
//  3. Drain backpressure: hist_ready low 5 cycles on bin3 -> hist_data/hist_bin stable; done only after bin7 handshake.
//  4. ACC_W=8, mag=255 to one bin for 2 pixels -> bin saturates at 255, no wrap.
//  5. rst_n low at cnt=100 -> all outputs reset. New start: full clean window, bin sums match model.
//  6. CENTER_WEIGHT_EN, mag=8 all pixels, rel=0 -> bin0 = 64*8 + 192*4 = 1280.
//     Without the macro: bin0 = 2048.

Source files
------------

// File: rtl/sift_dir_pkg.sv
// Shared types and constants for the orientation-histogram scan.
package sift_dir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int WIN       = 16;
   localparam int NBINS     = 8;
   localparam int ROM_AW    = 8;
   localparam int ROM_DW    = 5;
   localparam int ORI_STEPS = 32;
   localparam int BIN_W     = $clog2(NBINS);

   // Relative orientation wraps in 5 bits; the top three bits select the bin.
   function automatic logic [BIN_W-1:0] bin_of(input logic [ROM_DW-1:0] ori,
                                                input logic [ROM_DW-1:0] spo);
      logic [ROM_DW-1:0] rel;
      rel = ori - spo;
      return rel[ROM_DW-1:ROM_DW-BIN_W];
   endfunction

endpackage

// File: rtl/dir_hist_bank.sv
// Eight saturating magnitude accumulators with one add port and one read port.
module dir_hist_bank
   import sift_dir_pkg::*;
#(
   parameter int MAG_W = 8,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             add_en,
   input  logic [BIN_W-1:0] add_bin,
   input  logic [MAG_W-1:0] add_val,
   input  logic [BIN_W-1:0] rd_bin,
   output logic [ACC_W-1:0] rd_data
);

   localparam int SUM_W = ACC_W + 1;

   logic [ACC_W-1:0] acc [NBINS];
   logic [SUM_W-1:0] sum;
   logic [ACC_W-1:0] sat;

   // One spare bit catches the carry; a carry pins the bin at full scale.
   always_comb begin
      sum = {1'b0, acc[add_bin]} + SUM_W'(add_val);
      sat = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   end

   // Accumulator storage: clear wins over add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NBINS; i++) acc[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NBINS; i++) acc[i] <= '0;
      end else if (add_en) begin
         acc[add_bin] <= sat;
      end
   end

   assign rd_data = acc[rd_bin];

endmodule

// File: rtl/dir_hist_scan.sv
// Streams one 16x16 window of pixels against the direction-offset ROM, bins
// magnitudes by relative orientation, then drains the 8-bin histogram.
// Build option: DIR_HIST_CENTER_WEIGHT_EN halves the contribution of the
// outer 4-pixel ring of the window.
//
// state | meaning
// IDLE  | waiting for start, histogram from last window still held
// ACCUM | accepting pixels, rom_a tracks the pixel counter
// DRAIN | presenting bins 0..7 to the descriptor stage
module dir_hist_scan
   import sift_dir_pkg::*;
#(
   parameter int MAG_W = 8,
   parameter int ACC_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [ROM_DW-1:0] pix_ori,
   input  logic [MAG_W-1:0]  pix_mag,
   output logic [ROM_AW-1:0] rom_a,
   input  logic [ROM_DW-1:0] rom_spo,
   output logic              hist_valid,
   input  logic              hist_ready,
   output logic [BIN_W-1:0]  hist_bin,
   output logic [ACC_W-1:0]  hist_data,
   output logic              hist_last,
   output logic              done
);

   localparam logic [ROM_AW-1:0] CNT_LAST = {ROM_AW{1'b1}};
   localparam logic [BIN_W-1:0]  BIN_LAST = BIN_W'(NBINS - 1);

   state_t            state, state_nxt;
   logic [ROM_AW-1:0] cnt;
   logic [BIN_W-1:0]  bin_idx;
   logic              pix_hs, hist_hs, clear;
   logic [MAG_W-1:0]  add_val;
   logic [ACC_W-1:0]  rd_data;

   assign pix_hs  = (state == ACCUM) && pix_valid;
   assign hist_hs = (state == DRAIN) && hist_ready;
   assign clear   = (state == IDLE) && start;

`ifdef DIR_HIST_CENTER_WEIGHT_EN
   logic inner;
   // Rows/cols 4..11 have their top two index bits equal to 01 or 10.
   assign inner   = (cnt[7] ^ cnt[6]) && (cnt[3] ^ cnt[2]);
   assign add_val = inner ? pix_mag : (pix_mag >> 1);
`else
   assign add_val = pix_mag;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      pix_ready  = 1'b0;
      hist_valid = 1'b0;
      hist_last  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = ACCUM;
         end
         ACCUM: begin
            busy      = 1'b1;
            pix_ready = 1'b1;
            if (pix_valid && (cnt == CNT_LAST)) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy       = 1'b1;
            hist_valid = 1'b1;
            hist_last  = (bin_idx == BIN_LAST);
            if (hist_ready && (bin_idx == BIN_LAST)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pixel counter, drain index and completion pulse. Both counters wrap
   // back to zero naturally at the end of their phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         bin_idx <= '0;
         done    <= 1'b0;
      end else begin
         done <= hist_hs && (bin_idx == BIN_LAST);
         if (clear) begin
            cnt     <= '0;
            bin_idx <= '0;
         end else begin
            if (pix_hs)  cnt     <= cnt + 8'd1;
            if (hist_hs) bin_idx <= bin_idx + 3'd1;
         end
      end
   end

   dir_hist_bank #(
      .MAG_W (MAG_W),
      .ACC_W (ACC_W)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .add_en  (pix_hs),
      .add_bin (bin_of(pix_ori, rom_spo)),
      .add_val (add_val),
      .rd_bin  (bin_idx),
      .rd_data (rd_data)
   );

   assign rom_a     = cnt;
   assign hist_bin  = bin_idx;
   assign hist_data = (state == DRAIN) ? rd_data : '0;

endmodule
